// File: rtl/display_arbiter.sv
// display_arbiter: round-robin arbiter placing one of two requester bytes on a display for a minimum dwell time
module display_arbiter #(
  parameter int DWELL_CYCLES = 25000000,
  parameter int CNT_W = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       hold,
  output logic [7:0] disp_data,
  output logic [1:0] disp_src,
  output logic       busy
);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic last_src, last_src_nx;
  logic [7:0] disp_data_nx;
  logic [1:0] disp_src_nx;
  logic grant_ok, win1;
  // last_src is 1 when req1 was granted most recently; a tie goes to the other requester
  assign win1 = req1_valid & (~req0_valid | ~last_src);
  assign grant_ok = (state == IDLE) & reset & ~hold;
  assign req0_ready = grant_ok & req0_valid & ~win1;
  assign req1_ready = grant_ok & win1;
  assign busy = (state == DWELL);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    last_src_nx = last_src;
    disp_data_nx = disp_data;
    disp_src_nx = disp_src;
    if (req0_ready || req1_ready) begin
      state_nx = DWELL;
      cnt_nx = CNT_W'(DWELL_CYCLES - 1);
      last_src_nx = req1_ready;
      disp_data_nx = req1_ready ? req1_data : req0_data;
      disp_src_nx = req1_ready ? 2'b10 : 2'b01;
    end else if (state == DWELL) begin
      cnt_nx = (cnt != '0) ? cnt - 1'b1 : cnt;
      state_nx = (cnt == '0 && !hold) ? IDLE : DWELL;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      last_src <= 1'b1;
      disp_data <= 8'h00;
      disp_src <= 2'b00;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      last_src <= last_src_nx;
      disp_data <= disp_data_nx;
      disp_src <= disp_src_nx;
    end
  end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed vector table plus a bounded-wait sequence for display_arbiter
module tb_display_arbiter;
  logic clock = 1'b0;
  logic reset, hold, req0_valid, req1_valid, req0_ready, req1_ready, busy;
  logic [7:0] req0_data, req1_data, disp_data;
  logic [1:0] disp_src;
  int checks = 0;
  int fails = 0;

  display_arbiter #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .disp_data(disp_data), .disp_src(disp_src), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst_n, hold, v0;
    logic [7:0] d0;
    logic v1;
    logic [7:0] d1;
    logic r0, r1, busy;
    logic [7:0] dd;
    logic [1:0] ds;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst_n, hold, v0, input logic [7:0] d0, input logic v1,
                     input logic [7:0] d1, input logic r0, r1, bz, input logic [7:0] dd,
                     input logic [1:0] ds);
    vec_t v;
    v.rst_n = rst_n; v.hold = hold; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.busy = bz; v.dd = dd; v.ds = ds;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h00;
    req1_valid = 1'b1; req1_data = 8'h00;
    tick();
    #1;
    chk("reset_r0", -1, {7'd0, req0_ready}, 8'd0);
    chk("reset_r1", -1, {7'd0, req1_ready}, 8'd0);
    tick();
    //  rst hold v0 d0     v1 d1     r0 r1 bz dd     ds
    add(0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 2'b00);
    add(1, 0, 1, 8'hA5, 0, 8'h00, 1, 0, 0, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'hA5, 2'b01);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hA5, 2'b01);
    // both requesting continuously: req1 wins first since req0 was granted last
    add(1, 0, 1, 8'h11, 1, 8'h22, 0, 1, 0, 8'hA5, 2'b01);
    for (int i = 0; i < 4; i++) add(1, 0, 1, 8'h11, 1, 8'h22, 0, 0, 1, 8'h22, 2'b10);
    add(1, 0, 1, 8'h11, 1, 8'h22, 1, 0, 0, 8'h22, 2'b10);
    for (int i = 0; i < 4; i++) add(1, 0, 1, 8'h11, 1, 8'h22, 0, 0, 1, 8'h11, 2'b01);
    add(1, 0, 1, 8'h11, 1, 8'h22, 0, 1, 0, 8'h11, 2'b01);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h22, 2'b10);
    // hold in IDLE blocks the grant until released
    add(1, 1, 1, 8'h33, 0, 8'h00, 0, 0, 0, 8'h22, 2'b10);
    add(1, 1, 1, 8'h33, 0, 8'h00, 0, 0, 0, 8'h22, 2'b10);
    add(1, 0, 1, 8'h33, 0, 8'h00, 1, 0, 0, 8'h22, 2'b10);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h33, 2'b01);
    // hold during dwell stretches it past counter expiry
    for (int i = 0; i < 6; i++) add(1, 1, 0, 8'h00, 1, 8'h22, 0, 0, 1, 8'h33, 2'b01);
    add(1, 0, 0, 8'h00, 1, 8'h22, 0, 0, 1, 8'h33, 2'b01);
    add(1, 0, 0, 8'h00, 1, 8'h22, 0, 1, 0, 8'h33, 2'b01);
    // req1 pulse during dwell must not move the pointer
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h22, 2'b10);
    add(1, 0, 0, 8'h00, 1, 8'h66, 0, 0, 1, 8'h22, 2'b10);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h22, 2'b10);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h22, 2'b10);
    add(1, 0, 1, 8'h44, 1, 8'h22, 1, 0, 0, 8'h22, 2'b10);
    // reset in mid-dwell with req1 pending
    add(1, 0, 0, 8'h00, 1, 8'h22, 0, 0, 1, 8'h44, 2'b01);
    add(0, 0, 0, 8'h00, 1, 8'h22, 0, 0, 1, 8'h44, 2'b01);
    add(1, 0, 0, 8'h00, 1, 8'h22, 0, 1, 0, 8'h00, 2'b00);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h22, 2'b10);
    foreach (tbl[i]) begin
      reset = tbl[i].rst_n; hold = tbl[i].hold;
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
      #1;
      chk("req0_ready", i, {7'd0, req0_ready}, {7'd0, tbl[i].r0});
      chk("req1_ready", i, {7'd0, req1_ready}, {7'd0, tbl[i].r1});
      chk("busy", i, {7'd0, busy}, {7'd0, tbl[i].busy});
      chk("disp_data", i, disp_data, tbl[i].dd);
      chk("disp_src", i, {6'd0, disp_src}, {6'd0, tbl[i].ds});
      tick();
    end
    // dwell from last table grant has 3 cycles left; req0 must win in the 4th
    begin
      int waited = 0;
      req0_valid = 1'b1; req0_data = 8'h55;
      req1_valid = 1'b0;
      #1;
      while (!req0_ready && waited < 10) begin
        tick();
        waited++;
      end
      chk("grant_wait", 0, 8'(waited), 8'd3);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("final_data", 0, disp_data, 8'h55);
      chk("final_busy", 0, {7'd0, busy}, 8'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
